// File: rtl/pkt_sender.sv
// pkt_sender: builds the fixed 8-byte vehicle frame and sends it out one byte
// per valid/ready handshake. It also sends the broadcast kill frame on request.
// Optional feature: define PKT_SENDER_CHECKSUM_EN so that byte 7 is the XOR of
// bytes 0-6. When it is undefined, byte 7 is 8'h00 and no checksum logic exists.
module pkt_sender #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         IFG_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  veh_id,
    input  logic [15:0] req_data,
    input  logic [7:0]  req_dst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        kill_req,
    output logic [7:0]  tx_frame,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  seq
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    // Variable frame fields, captured at latch time. Sync and check are derived.
    typedef struct packed {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [7:0]  sq;
        logic [15:0] data;
        logic [7:0]  flags;
    } frame_t;

    localparam frame_t KILL_TMPL = '{src: 8'h00, dst: 8'hFF, sq: 8'hFF,
                                     data: 16'hFFFF, flags: 8'h01};
    localparam logic [15:0] GAP_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  seq_nxt;
    logic        kill_pend, kill_pend_nxt;
    logic        kill_latch;
    frame_t      frm, frm_nxt;
    logic [15:0] gap_cnt, gap_nxt;
    logic [7:0]  tx_frame_nxt;
    logic        tx_valid_nxt;
    logic        busy_nxt;

    // Byte i of the held frame, byte 0 first.
    function automatic logic [7:0] frame_byte(input frame_t f, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = f.src;
            3'd2:    b = f.dst;
            3'd3:    b = f.sq;
            3'd4:    b = f.data[15:8];
            3'd5:    b = f.data[7:0];
            3'd6:    b = f.flags;
`ifdef PKT_SENDER_CHECKSUM_EN
            default: b = SYNC_BYTE ^ f.src ^ f.dst ^ f.sq ^ f.data[15:8] ^
                         f.data[7:0] ^ f.flags;
`else
            default: b = 8'h00;
`endif
        endcase
        return b;
    endfunction

    // State, frame hold and registered outputs. Reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            seq       <= 8'h00;
            kill_pend <= 1'b0;
            frm       <= '0;
            gap_cnt   <= 16'd0;
            tx_frame  <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            seq       <= seq_nxt;
            kill_pend <= kill_pend_nxt;
            frm       <= frm_nxt;
            gap_cnt   <= gap_nxt;
            tx_frame  <= tx_frame_nxt;
            tx_valid  <= tx_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state logic: latch kill or normal frame in IDLE, step bytes in SEND,
    // count the inter-frame gap in GAP.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        seq_nxt      = seq;
        frm_nxt      = frm;
        gap_nxt      = gap_cnt;
        tx_frame_nxt = tx_frame;
        tx_valid_nxt = tx_valid;
        kill_latch   = 1'b0;
        req_ready    = 1'b0;

        case (state)
            IDLE: begin
                req_ready = ~kill_pend & ~kill_req;
                if (kill_pend || kill_req) begin
                    // Kill wins; a simultaneous payload request stays pending.
                    kill_latch   = 1'b1;
                    frm_nxt      = KILL_TMPL;
                    frm_nxt.src  = veh_id;
                    state_nxt    = SEND;
                    idx_nxt      = 3'd0;
                    tx_frame_nxt = SYNC_BYTE;
                    tx_valid_nxt = 1'b1;
                end else if (req_valid) begin
                    frm_nxt.src   = veh_id;
                    frm_nxt.dst   = req_dst;
                    frm_nxt.sq    = seq;
                    frm_nxt.data  = req_data;
                    frm_nxt.flags = 8'h00;
                    // 8'hFF is reserved for kill frames, so the counter skips it.
                    seq_nxt       = (seq == 8'hFE) ? 8'h00 : seq + 8'd1;
                    state_nxt     = SEND;
                    idx_nxt       = 3'd0;
                    tx_frame_nxt  = SYNC_BYTE;
                    tx_valid_nxt  = 1'b1;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx == 3'd7) begin
                        idx_nxt      = 3'd0;
                        tx_valid_nxt = 1'b0;
                        tx_frame_nxt = 8'h00;
                        gap_nxt      = 16'd0;
                        state_nxt    = (IFG_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        idx_nxt      = idx + 3'd1;
                        tx_frame_nxt = frame_byte(frm, idx + 3'd1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                tx_valid_nxt = 1'b0;
                tx_frame_nxt = 8'h00;
            end
        endcase

        // A kill request seen in any state is remembered until its frame latches.
        kill_pend_nxt = kill_latch ? 1'b0 : (kill_pend | kill_req);
        busy_nxt      = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_pkt_sender.sv
// tb_pkt_sender: scoreboard bench for pkt_sender. Expected frames are built by
// a small model and queued when a request or kill is driven; the monitor pops
// and compares one byte per tx handshake.
module tb_pkt_sender;

    localparam int         IFG  = 4;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef PKT_SENDER_CHECKSUM_EN
    localparam logic [7:0] T1_CK = 8'hD2;
`else
    localparam logic [7:0] T1_CK = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  veh_id;
    logic [15:0] req_data;
    logic [7:0]  req_dst;
    logic        req_valid;
    logic        req_ready;
    logic        kill_req;
    logic [7:0]  tx_frame;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  seq;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_seq;
    bit          stall_mode = 1'b0;
    int          ph = 0;

    typedef struct {
        logic [7:0]  veh;
        logic [7:0]  dst;
        logic [15:0] data;
        logic [7:0]  exp_seq;
    } vec_t;
    vec_t tbl[5];

    pkt_sender #(.SYNC_BYTE(SYNC), .IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst(rst), .veh_id(veh_id), .req_data(req_data),
        .req_dst(req_dst), .req_valid(req_valid), .req_ready(req_ready),
        .kill_req(kill_req), .tx_frame(tx_frame), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .seq(seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] s, input logic [7:0] d, input logic [7:0] q,
                              input logic [15:0] dat, input logic [7:0] fl);
        logic [7:0] b[8];
        b = '{SYNC, s, d, q, dat[15:8], dat[7:0], fl, 8'h00};
`ifdef PKT_SENDER_CHECKSUM_EN
        for (int i = 0; i < 7; i++) b[7] = b[7] ^ b[i];
`endif
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    endtask

    task automatic push_kill(input logic [7:0] s);
        push_frame(s, 8'hFF, 8'hFF, 16'hFFFF, 8'h01);
    endtask

    // Drive a request, wait for acceptance, queue the model frame, then scramble
    // the inputs so that any post-latch dependence shows up as a wrong byte.
    task automatic send_req(input logic [7:0] v, input logic [7:0] d, input logic [15:0] dat);
        int n = 0;
        @(negedge clk);
        veh_id = v; req_dst = d; req_data = dat; req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        chk("seq_at_accept", 32'(seq), 32'(exp_seq));
        push_frame(v, d, exp_seq, dat, 8'h00);
        exp_seq = (exp_seq == 8'hFE) ? 8'h00 : exp_seq + 8'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_data = ~dat; req_dst = ~d; veh_id = ~v;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    // Sink: honours the 1-0-0-1 stall pattern when enabled, else always ready.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                tx_ready = (ph % 4 == 0) || (ph % 4 == 3);
                ph++;
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // Monitor: compare each handshaken byte, and check holds while stalled.
    initial begin : mon
        logic       stalled;
        logic [7:0] hb;
        stalled = 1'b0;
        hb      = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_hold_valid", 32'(tx_valid), 32'd1);
                    chk("stall_hold_byte", 32'(tx_frame), 32'(hb));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got %0h, want no byte", tx_frame);
                    end else begin
                        chk("tx_byte", 32'(tx_frame), 32'(exp_q.pop_front()));
                    end
                    stalled = 1'b0;
                end else if (tx_valid) begin
                    stalled = 1'b1;
                    hb      = tx_frame;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b1[8];
        logic [7:0] t1_exp[8];
        logic [7:0] seq_keep;

        tbl[0] = '{8'h01, 8'h02, 16'h0000, 8'h01};
        tbl[1] = '{8'hFF, 8'h00, 16'hFFFF, 8'h02};
        tbl[2] = '{8'h5A, 8'hA5, 16'h1234, 8'h03};
        tbl[3] = '{8'h00, 8'hFF, 16'h8001, 8'h04};
        tbl[4] = '{8'h77, 8'h88, 16'hFFFE, 8'h05};
        t1_exp = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'hBE, 8'hEF, 8'h00, T1_CK};

        rst = 1'b1; veh_id = 8'h00; req_data = 16'h0; req_dst = 8'h0;
        req_valid = 1'b0; kill_req = 1'b0; exp_seq = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_frame", 32'(tx_frame), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_seq", 32'(seq), 32'h00);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // Basic frame: exact bytes, latency, gap length.
        send_req(8'h12, 8'h34, 16'hBEEF);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_req_ready_send", 32'(req_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_valid_run", 32'(tx_valid), 32'd1);
            b1[i] = tx_frame;
        end
        for (int i = 0; i < 8; i++) chk("t1_byte_const", 32'(b1[i]), 32'(t1_exp[i]));
        chk("t1_seq_after", 32'(seq), 32'h01);
        @(negedge clk);
        chk("t1_valid_fall", 32'(tx_valid), 32'd0);
        chk("t1_gap_busy", 32'(busy), 32'd1);
        chk("t1_gap_ready0", 32'(req_ready), 32'd0);
        for (int i = 1; i < IFG; i++) begin
            @(negedge clk);
            chk("t1_gap_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        chk("t1_ready_after_gap", 32'(req_ready), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);

        // Table of back-to-back frames.
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            chk("tbl_seq", 32'(seq), 32'(tbl[r].exp_seq));
            send_req(tbl[r].veh, tbl[r].dst, tbl[r].data);
        end
        drain();

        // Kill pulse mid-frame: current frame completes, then kill frame.
        send_req(8'h12, 8'h56, 16'hCAFE);
        veh_id = 8'h12;
        repeat (3) @(negedge clk);
        kill_req = 1'b1;
        push_kill(8'h12);
        @(negedge clk);
        kill_req = 1'b0;
        seq_keep = exp_seq;
        drain();
        chk("kill_seq_unchanged", 32'(seq), 32'(seq_keep));

        // Kill and request together in IDLE: kill first, request afterwards.
        @(negedge clk);
        veh_id = 8'h12; req_dst = 8'h9A; req_data = 16'h1357;
        kill_req = 1'b1; req_valid = 1'b1;
        #1;
        chk("both_req_ready", 32'(req_ready), 32'd0);
        push_kill(8'h12);
        @(posedge clk);
        #1;
        kill_req = 1'b0;
        send_req(8'h12, 8'h9A, 16'h1357);
        drain();

        // Stalling sink.
        stall_mode = 1'b1;
        send_req(8'h21, 8'h43, 16'h6587);
        send_req(8'h31, 8'h42, 16'h5364);
        drain();
        stall_mode = 1'b0;

        // Reset during byte 4.
        send_req(8'h44, 8'h55, 16'h6677);
        repeat (5) @(negedge clk);
        chk("rst_mid_at_b4", 32'(tx_frame), 32'h66);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_seq = 8'h00;
        #1;
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_tx_frame", 32'(tx_frame), 32'h00);
        chk("rst_mid_seq", 32'(seq), 32'h00);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_req(8'h12, 8'h34, 16'hBEEF);
        drain();
        chk("rst_mid_seq_after", 32'(seq), 32'h01);

        // Full sequence sweep from reset: 0x00..0xFE then wrap to 0x00.
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_seq = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 255; i++) begin
            send_req(8'(i), 8'(~i), {8'(i), 8'(~i)});
        end
        drain();
        chk("wrap_seq", 32'(seq), 32'h00);
        send_req(8'hAB, 8'hCD, 16'hEF01);
        drain();

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_sender.md
# pkt_sender

Transmit-side counterpart of the vehicle packet receiver. It accepts a 16-bit payload and a destination vehicle ID from local logic, builds the fixed 8-byte vehicle frame, and serializes it one byte per valid/ready handshake toward the byte link (UART/radio shim). It also emits the broadcast kill frame on request. In the kill frame, bytes 2–5 are all 0xFF, which receivers decode as the kill command.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, value of frame byte 0
- IFG_CYCLES, 4, idle cycles inserted after each frame (0 allowed)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- veh_id  in  8  own vehicle ID; sampled when a frame is latched
- req_data  in  16  payload
- req_dst  in  8  destination vehicle ID
- req_valid  in  1  payload request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- kill_req  in  1  single-cycle or level request to send the kill frame
- tx_frame  out  8  current outgoing byte
- tx_valid  out  1  tx_frame valid
- tx_ready  in  1  byte consumed when tx_valid && tx_ready
- busy  out  1  high in SEND or GAP
- seq  out  8  sequence number for the next normal frame

## Operation
- Frame byte order, byte 0 first: SYNC_BYTE, src veh_id, dst, seq, data[15:8], data[7:0], flags, check.
- Normal frames:
  - flags = 8'h00.
  - After the frame is latched, seq increments and skips 8'hFF (8'hFE → 8'h00). Bytes 2–5 of a normal frame therefore can never all be 0xFF.
- Kill frame:
  - dst = 8'hFF, seq byte = 8'hFF, data = 16'hFFFF, flags = 8'h01.
  - seq does not increment.
- kill_pend flag:
  - Set on any cycle with kill_req = 1, in any state.
  - Cleared when the kill frame is latched.
  - A kill request is never lost while a frame is in flight.
- States:
  - IDLE: req_ready = ~kill_pend && ~kill_req. If kill_pend || kill_req, latch the kill frame and go to SEND. Else if req_valid, latch the normal frame and go to SEND. Kill wins over a simultaneous req_valid, and that request is not accepted.
  - SEND: tx_valid = 1, tx_frame = byte[idx]. Each handshake increments the 3-bit idx. On the handshake with idx = 7, go to GAP if IFG_CYCLES > 0, else IDLE.
  - GAP: tx_valid = 0. Count IFG_CYCLES cycles, then go to IDLE.
- req_ready is 0 in SEND and GAP.
- Held frame contents are unaffected by changes on req_* or veh_id after latch.

## Timing
- Reset values:
  - IDLE, idx = 0, seq = 8'h00, kill_pend = 0
  - tx_valid = 0, tx_frame = 8'h00, busy = 0
  - req_ready = 1 after reset (combinational from state and kill inputs)
- tx_frame, tx_valid and busy are registered.
- Latency:
  - Accept or kill latch at edge N; tx_valid = 1 with byte 0 from N+1.
  - With tx_ready held 1, bytes 0–7 go out on cycles N+1..N+8, and tx_valid falls at N+9.
  - Next accept is possible at the edge of cycle N+9+IFG_CYCLES.
- While tx_valid && !tx_ready, tx_frame is held stable; tx_valid is never withdrawn mid-frame.
- tx_ready while tx_valid = 0 is ignored.
- Asserting rst mid-frame aborts immediately to reset values; the partial frame is not resumed.

## Configuration
- PKT_SENDER_CHECKSUM_EN defined: byte 7 = XOR of bytes 0–6.
- Undefined: byte 7 = 8'h00. Checksum logic is absent.

## Test plan
- veh_id = 0x12, req_dst = 0x34, req_data = 0xBEEF after reset, tx_ready = 1 → bytes A5 12 34 00 BE EF 00 D2 (D2 with checksum, 00 without) on consecutive cycles; seq = 0x01 afterwards.
- 1-cycle kill_req pulse mid-frame with veh_id = 0x12 → current frame completes unchanged; after the gap, A5 12 FF FF FF FF 01 B6 is sent; seq is unchanged.
- kill_req and req_valid both asserted in IDLE → kill frame is sent first, req_ready = 0 that cycle; the request is accepted in the following IDLE.
- tx_ready toggled 1-0-0-1 repeatedly → every byte is held while stalled, no byte is dropped or duplicated, and order is preserved.
- 255 back-to-back normal frames → seq goes 0x00..0xFE, then 0x00; the byte 3 value 0xFF never appears.
- rst asserted during byte 4 → tx_valid = 0, tx_frame = 0x00, seq = 0x00 immediately; a new request then sends a complete frame starting from byte 0.
